approx_adder_err_monitor: RTL and testbench
===========================================

Name: approx_adder_err_monitor

Overview:
Downstream error-characterisation stage for the 16-bit approximate ripple-carry adders. Consumes the operand pair and the 17-bit approximate sum produced by an adder under test. Computes the exact sum internally and accumulates error metrics over a window of 2^LOG2_N samples: error count, sum of error distance, sum of squared error, and worst-case error. Results feed MED/MSE/ER/WCE reporting without a software post-pass.

Parameters:
W, 16, operand width; sums are W+1 bits
LOG2_N, 10, log2 of window length in accepted samples (window N = 2^LOG2_N, 1..20)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms a new window (honoured only in IDLE)
in_valid  input  1  sample valid
in_ready  output  1  sample accepted when in_valid && in_ready
in_a  input  W  operand A
in_b  input  W  operand B
in_approx  input  W+1  approximate sum from adder under test
res_valid  output  1  result bundle valid
res_ready  input  1  result consumed when res_valid && res_ready
err_count  output  LOG2_N+1  samples with in_approx != exact sum
sum_ed  output  W+1+LOG2_N  sum of |approx - exact|
sum_sq  output  2*(W+1)+LOG2_N  sum of (approx - exact)^2
max_ed  output  W+1  maximum |approx - exact| in window
busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset (async assert, sync-to-clk deassert is not required of the block): state=IDLE; in_ready=0, res_valid=0, busy=0; all result outputs and accumulators = 0; sample counter = 0; pipeline valid bits = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN; clear accumulators, counter, and max_ed in the same edge.
  - RUN: in_ready=1. Each accepted sample increments the counter. The acceptance that makes count == N moves the FSM to DRAIN; in_ready is 0 from the next cycle.
  - DRAIN: wait until both pipeline stages are empty (exactly 2 cycles after the last accept), then go to DONE.
  - DONE: res_valid=1, outputs stable. res_ready -> IDLE next cycle, res_valid=0. Outputs keep their values until the next start clears them.
- start outside IDLE is ignored. in_valid outside RUN is ignored, and no state changes.
- Pipeline:
  - S1 registers exact = in_a + in_b (W+1 bits, zero-extended) and diff = in_approx - exact (signed W+2 bits).
  - S2 registers ed = |diff| (W+1 bits) and sq = diff*diff (2W+2 bits).
  - Accumulate stage updates sum_ed, sum_sq, max_ed, and err_count (increments when diff != 0).
  - Latency from accept to accumulator update: 3 cycles. Throughput: 1 sample/cycle.
- Widths are sized so accumulators cannot overflow for N samples. No saturation logic.
- max_ed update uses strict greater-than. Ties keep the stored value.
- The pipeline advances unconditionally and carries no backpressure; stage valid bits gate accumulation.
- Reset mid-window: everything returns to the reset values and partial results are discarded.

Decomposition:
- Package approx_err_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - localparams SUM_W=W+1, DIFF_W=W+2, SQ_W=2*(W+1)
  - accumulator width functions
- One sub-module, approx_err_datapath: the exact adder, diff, abs, and square pipeline (S1/S2) with valid propagation.
- The top level holds the FSM, counter, and accumulators.

Test Plan:
1. LOG2_N=2, start; samples (3,5,approx 6), (1,1,2), (0,0,0), (10,4,15) -> err_count=2, sum_ed=3, sum_sq=5, max_ed=2; res_valid asserted 3 cycles after last accept.
2. LOG2_N=2, all samples exact (e.g. 0xFFFF+0xFFFF, approx 0x1FFFE) -> err_count=0, sum_ed=0, sum_sq=0, max_ed=0.
3. LOG2_N=1, a=0xFFFF, b=0xFFFF, approx=0 twice -> ed=0x1FFFE each; sum_ed=0x3FFFC, sum_sq=2*0x1FFFE^2, max_ed=0x1FFFE (width boundary).
4. Handshake: in_valid held high in IDLE for 5 cycles, then start -> no samples counted before start; in_ready drops the cycle after the Nth accept; res_ready held low 4 cycles -> res_valid and outputs stable throughout.
5. Gapped in_valid (1 of every 3 cycles) with N=4 -> same totals as scenario 1; start pulsed during RUN has no effect.
6. Assert rst_n low after 2 accepted samples -> all outputs 0 immediately (async); new start plus scenario 1 stimulus reproduces scenario 1 results.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// Widths follow from the operand width W and the window exponent LOG2_N.
package approx_err_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int W_DEF  = 16;
  localparam int SUM_W  = W_DEF + 1;
  localparam int DIFF_W = W_DEF + 2;
  localparam int SQ_W   = 2 * (W_DEF + 1);

  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  function automatic int diff_w(input int w);
    return w + 2;
  endfunction

  function automatic int sq_w(input int w);
    return 2 * (w + 1);
  endfunction

  // Accumulators grow by LOG2_N bits so a full window of worst-case samples fits.
  function automatic int ed_acc_w(input int w, input int log2_n);
    return w + 1 + log2_n;
  endfunction

  function automatic int sq_acc_w(input int w, input int log2_n);
    return 2 * (w + 1) + log2_n;
  endfunction

  function automatic int cnt_w(input int log2_n);
    return log2_n + 1;
  endfunction

endpackage

// File: rtl/approx_err_datapath.sv
// Two-stage error pipeline: exact sum and signed difference, then |diff| and diff^2.
// Free-running; the valid bits tell the accumulator which stage outputs are real.
module approx_err_datapath
  import approx_err_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_p0,
  input  logic [W-1:0]          a_p0,
  input  logic [W-1:0]          b_p0,
  input  logic [W:0]            approx_p0,
  output logic                  vld_p1,
  output logic                  vld_p2,
  output logic                  nz_p2,
  output logic [sum_w(W)-1:0]   ed_p2,
  output logic [sq_w(W)-1:0]    sq_p2
);

  localparam int SW = sum_w(W);
  localparam int DW = diff_w(W);
  localparam int QW = sq_w(W);

  // |diff| always fits in SW bits: the difference of two SW-bit unsigned values.
  function automatic logic [SW-1:0] abs_ed(input logic signed [DW-1:0] d);
    return d[DW-1] ? SW'(-d) : SW'(d);
  endfunction

  logic [SW-1:0]        exact_p0;
  logic signed [DW-1:0] diff_p0;
  logic signed [DW-1:0] diff_p1;
  logic [SW-1:0]        ed_p1;

  assign exact_p0 = SW'(a_p0) + SW'(b_p0);
  assign diff_p0  = $signed(DW'(approx_p0)) - $signed(DW'(exact_p0));
  assign ed_p1    = abs_ed(diff_p1);

  // S1
  always_ff @(posedge clk) begin
    diff_p1 <= diff_p0;
  end

  // S2
  always_ff @(posedge clk) begin
    ed_p2 <= ed_p1;
    sq_p2 <= QW'(ed_p1) * QW'(ed_p1);
    nz_p2 <= (diff_p1 != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Error-metric accumulator for an approximate adder over a window of 2^LOG2_N samples.
// Holds the window FSM, sample counter and the ED / SE / WCE / error-count accumulators.
module approx_adder_err_monitor
  import approx_err_pkg::*;
#(
  parameter int W      = 16,
  parameter int LOG2_N = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [W-1:0]                    in_a,
  input  logic [W-1:0]                    in_b,
  input  logic [W:0]                      in_approx,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [cnt_w(LOG2_N)-1:0]        err_count,
  output logic [ed_acc_w(W, LOG2_N)-1:0]  sum_ed,
  output logic [sq_acc_w(W, LOG2_N)-1:0]  sum_sq,
  output logic [sum_w(W)-1:0]             max_ed,
  output logic                            busy
);

  localparam int SW  = sum_w(W);
  localparam int QW  = sq_w(W);
  localparam int CW  = cnt_w(LOG2_N);
  localparam int EAW = ed_acc_w(W, LOG2_N);
  localparam int QAW = sq_acc_w(W, LOG2_N);
  localparam logic [CW-1:0] N_LAST = CW'((1 << LOG2_N) - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic            accept;
  logic            vld_p1, vld_p2, nz_p2;
  logic [SW-1:0]   ed_p2;
  logic [QW-1:0]   sq_p2;

  assign accept    = in_valid && (state == RUN);
  assign in_ready  = (state == RUN);
  assign res_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DRAIN);

  approx_err_datapath #(.W(W)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_p0    (accept),
    .a_p0      (in_a),
    .b_p0      (in_b),
    .approx_p0 (in_approx),
    .vld_p1    (vld_p1),
    .vld_p2    (vld_p2),
    .nz_p2     (nz_p2),
    .ed_p2     (ed_p2),
    .sq_p2     (sq_p2)
  );

  // With S1 empty, the last sample leaves S2 into the accumulators on this edge.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && (count == N_LAST)) state_nx = DRAIN;
      DRAIN:   if (!vld_p1) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Accumulate stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      sum_sq    <= '0;
      max_ed    <= '0;
    end else if ((state == IDLE) && start) begin
      count     <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      sum_sq    <= '0;
      max_ed    <= '0;
    end else begin
      if (accept) count <= count + CW'(1);
      if (vld_p2) begin
        err_count <= err_count + CW'(nz_p2);
        sum_ed    <= sum_ed + EAW'(ed_p2);
        sum_sq    <= sum_sq + QAW'(sq_p2);
        if (ed_p2 > max_ed) max_ed <= ed_p2;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Scoreboard bench: expected windows are queued at start, a negedge monitor checks each consumed result.
// u0 runs N=4 windows, u1 runs N=2 for the width-boundary case.
module tb_approx_adder_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic [16:0] in_approx = '0;

  logic        in_ready0, res_valid0, busy0;
  logic [2:0]  err_count0;
  logic [18:0] sum_ed0;
  logic [35:0] sum_sq0;
  logic [16:0] max_ed0;

  logic        in_ready1, res_valid1, busy1;
  logic [1:0]  err_count1;
  logic [17:0] sum_ed1;
  logic [34:0] sum_sq1;
  logic [16:0] max_ed1;

  typedef struct {
    logic [63:0] ec;
    logic [63:0] ed;
    logic [63:0] sq;
    logic [63:0] mx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  approx_adder_err_monitor #(.W(16), .LOG2_N(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .res_valid(res_valid0),
    .res_ready(res_ready), .err_count(err_count0), .sum_ed(sum_ed0), .sum_sq(sum_sq0),
    .max_ed(max_ed0), .busy(busy0)
  );

  approx_adder_err_monitor #(.W(16), .LOG2_N(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .res_valid(res_valid1),
    .res_ready(res_ready), .err_count(err_count1), .sum_ed(sum_ed1), .sum_sq(sum_sq1),
    .max_ed(max_ed1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
    in_a = a;
    in_b = b;
    in_approx = ap;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_u0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic start_u1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic scen1_samples();
    send(16'd3, 16'd5, 17'd6);
    send(16'd1, 16'd1, 17'd2);
    send(16'd0, 16'd0, 17'd0);
    send(16'd10, 16'd4, 17'd15);
  endtask

  task automatic drain_wait(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!busy0 && !res_valid0 && !busy1 && !res_valid1) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) chk(name, 64'(busy0 | res_valid0 | busy1 | res_valid1), 64'd0);
  endtask

  // Scoreboard monitors: a result is consumed when valid and ready meet.
  always @(negedge clk) begin
    if (rst_n && res_valid0 && res_ready) begin
      if (q0.size() == 0) chk("u0_unexpected_result", 64'(q0.size()), 64'd1);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("u0_err_count", 64'(err_count0), e.ec);
        chk("u0_sum_ed", 64'(sum_ed0), e.ed);
        chk("u0_sum_sq", 64'(sum_sq0), e.sq);
        chk("u0_max_ed", 64'(max_ed0), e.mx);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && res_valid1 && res_ready) begin
      if (q1.size() == 0) chk("u1_unexpected_result", 64'(q1.size()), 64'd1);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_err_count", 64'(err_count1), e.ec);
        chk("u1_sum_ed", 64'(sum_ed1), e.ed);
        chk("u1_sum_sq", 64'(sum_sq1), e.sq);
        chk("u1_max_ed", 64'(max_ed1), e.mx);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready0), 64'd0);
    chk("rst_res_valid", 64'(res_valid0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_err_count", 64'(err_count0), 64'd0);
    chk("rst_sum_ed", 64'(sum_ed0), 64'd0);
    chk("rst_sum_sq", 64'(sum_sq0), 64'd0);
    chk("rst_max_ed", 64'(max_ed0), 64'd0);
    chk("rst_u1_busy", 64'(busy1), 64'd0);
    rst_n = 1'b1;
    tick();
    res_ready = 1'b1;

    // 1: mixed errors, plus result latency
    start_u0();
    chk("run_in_ready", 64'(in_ready0), 64'd1);
    chk("run_busy", 64'(busy0), 64'd1);
    q0.push_back('{64'd2, 64'd3, 64'd5, 64'd2});
    scen1_samples();
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (res_valid0) begin
        lat = i;
        break;
      end
    end
    chk("res_latency", 64'(lat), 64'd3);
    tick();
    drain_wait("s1_drain_timeout");

    // 2: all samples exact
    start_u0();
    q0.push_back('{64'd0, 64'd0, 64'd0, 64'd0});
    send(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    send(16'h0000, 16'h0000, 17'h00000);
    send(16'h1234, 16'h0001, 17'h01235);
    send(16'h8000, 16'h8000, 17'h10000);
    drain_wait("s2_drain_timeout");

    // 3: width boundary on the N=2 instance
    start_u1();
    q1.push_back('{64'd2, 64'h3FFFC, 64'h7FFF00008, 64'h1FFFE});
    send(16'hFFFF, 16'hFFFF, 17'h0);
    send(16'hFFFF, 16'hFFFF, 17'h0);
    drain_wait("s3_drain_timeout");

    // 4: in_valid before start, in_ready drop, stalled result
    res_ready = 1'b0;
    in_a = 16'd100;
    in_b = 16'd0;
    in_approx = 17'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_in_ready", 64'(in_ready0), 64'd0);
      if (i == 4) start0 = 1'b1;
      tick();
    end
    start0 = 1'b0;
    in_valid = 1'b0;
    q0.push_back('{64'd2, 64'd3, 64'd5, 64'd2});
    send(16'd3, 16'd5, 17'd6);
    send(16'd1, 16'd1, 17'd2);
    send(16'd0, 16'd0, 17'd0);
    chk("pre_last_in_ready", 64'(in_ready0), 64'd1);
    send(16'd10, 16'd4, 17'd15);
    chk("post_last_in_ready", 64'(in_ready0), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("s4_res_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_res_valid", 64'(res_valid0), 64'd1);
      chk("hold_err_count", 64'(err_count0), 64'd2);
      chk("hold_sum_sq", 64'(sum_sq0), 64'd5);
      chk("hold_max_ed", 64'(max_ed0), 64'd2);
      tick();
    end
    res_ready = 1'b1;
    drain_wait("s4_drain_timeout");
    chk("after_done_err_count", 64'(err_count0), 64'd2);

    // 5: gapped input, stray start during RUN
    start_u0();
    q0.push_back('{64'd2, 64'd3, 64'd5, 64'd2});
    send(16'd3, 16'd5, 17'd6);
    tick();
    tick();
    send(16'd1, 16'd1, 17'd2);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    send(16'd0, 16'd0, 17'd0);
    tick();
    tick();
    send(16'd10, 16'd4, 17'd15);
    drain_wait("s5_drain_timeout");

    // 6: reset mid-window, then a clean rerun
    start_u0();
    send(16'd3, 16'd5, 17'd6);
    send(16'd10, 16'd4, 17'd15);
    tick();
    tick();
    tick();
    chk("midwin_err_count", 64'(err_count0), 64'd2);
    chk("midwin_sum_ed", 64'(sum_ed0), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_err_count", 64'(err_count0), 64'd0);
    chk("async_rst_sum_ed", 64'(sum_ed0), 64'd0);
    chk("async_rst_sum_sq", 64'(sum_sq0), 64'd0);
    chk("async_rst_max_ed", 64'(max_ed0), 64'd0);
    chk("async_rst_busy", 64'(busy0), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready0), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_u0();
    q0.push_back('{64'd2, 64'd3, 64'd5, 64'd2});
    scen1_samples();
    drain_wait("s6_drain_timeout");

    chk("u0_scoreboard_empty", 64'(q0.size()), 64'd0);
    chk("u1_scoreboard_empty", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
